// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster generator: mode encodings, default
// 640x480@60 timing, the per-pixel control payload and colour-index mapping.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BLACK = 2'd3
  } mode_e;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  // Per-pixel control travelling down the delay line alongside the colour.
  typedef struct packed {
    logic  de;
    logic  hs;
    logic  vs;
    logic  frame;
    mode_e mode;
  } ctl_t;

  localparam ctl_t CTL_BLANK = '{de: 1'b0, hs: 1'b0, vs: 1'b0, frame: 1'b0, mode: MODE_EXT};

  // Colour bars run white..black, so the colour index is 7 - bar, i.e. ~bar.
  function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
    return ~bar;
  endfunction

  // Checkerboard colour index to {R,G,B}.
  function automatic logic [2:0] checker_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b100;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b010;
      3'd3:    rgb = 3'b011;
      3'd4:    rgb = 3'b001;
      3'd5:    rgb = 3'b101;
      3'd6:    rgb = 3'b000;
      default: rgb = 3'b111;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_pattern.sv
// Built-in test-pattern generator; its output is delayed by LATENCY clocks so it
// lines up with an external pixel fetched for the same counter position.
module vga_pattern
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10,
  parameter int unsigned LATENCY  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  mode_e         mode_i,
  output logic [2:0]    rgb_o
);

  localparam int unsigned BW = XW + 3;

  logic [2:0] rgb_c;
  logic [2:0] bar_c;
  logic [2:0] chk_c;
  logic [2:0] pipe_q [LATENCY];
  logic [2:0] pipe_d [LATENCY];

  // One bit per component; the top widens it to the colour depth.
  always_comb begin
    bar_c = 3'({x_i, 3'b000} / BW'(H_ACTIVE));
    chk_c = 3'(x_i >> 4) + 3'(y_i >> 4);
    rgb_c = 3'b000;
    case (mode_i)
      MODE_BARS:  rgb_c = bar_rgb(bar_c);
      MODE_CHECK: rgb_c = checker_rgb(chk_c);
      default:    rgb_c = 3'b000;
    endcase
  end

  always_comb begin
    pipe_d[0] = rgb_c;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= 3'b000;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign rgb_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster generator: counters, sync decode, LATENCY-deep control
// delay line and registered colour/sync outputs, external or built-in pixels.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned COLOR_BITS = 1,
  parameter int unsigned LATENCY    = 1,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned XW        = $clog2(H_TOTAL),
  localparam int unsigned YW        = $clog2(V_TOTAL)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [1:0]              Mode_i,
  input  logic [3*COLOR_BITS-1:0] Pixel_i,
  output logic                    Request_o,
  output logic [XW-1:0]           X_o,
  output logic [YW-1:0]           Y_o,
  output logic [COLOR_BITS-1:0]   Red_o,
  output logic [COLOR_BITS-1:0]   Green_o,
  output logic [COLOR_BITS-1:0]   Blue_o,
  output logic                    HSync_o,
  output logic                    VSync_o,
  output logic                    DE_o,
  output logic                    Frame_o
);

  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [XW-1:0]         h_q, h_d;
  logic [YW-1:0]         v_q, v_d;
  mode_e                 mode_q, mode_d;
  logic                  h_last_c, v_last_c;
  ctl_t                  cur_c, tail_c;
  ctl_t                  dly_q [LATENCY];
  ctl_t                  dly_d [LATENCY];
  logic [2:0]            pat_rgb;
  logic [COLOR_BITS-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                  hsync_q, hsync_d, vsync_q, vsync_d;
  logic                  de_q, de_d, frame_q, frame_d;

  // Raster counters; the mode only changes on the last pixel of a frame.
  always_comb begin
    h_last_c = (32'(h_q) == H_TOTAL - 1);
    v_last_c = (32'(v_q) == V_TOTAL - 1);
    h_d      = h_last_c ? '0 : h_q + XW'(1);
    v_d      = v_q;
    if (h_last_c) begin
      v_d = v_last_c ? '0 : v_q + YW'(1);
    end
    mode_d = (h_last_c && v_last_c) ? mode_e'(Mode_i) : mode_q;
  end

  always_comb begin
    cur_c.de    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    cur_c.hs    = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    cur_c.vs    = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
    cur_c.frame = (h_q == '0) && (v_q == '0);
    cur_c.mode  = mode_q;
  end

  always_comb begin
    dly_d[0] = cur_c;
    for (int i = 1; i < LATENCY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  assign tail_c = dly_q[LATENCY-1];

  // Final output register: colour source chosen by the mode carried with the pixel.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    de_d    = tail_c.de;
    hsync_d = tail_c.hs ? H_POL : !H_POL;
    vsync_d = tail_c.vs ? V_POL : !V_POL;
    frame_d = tail_c.frame;
    if (tail_c.de) begin
      case (tail_c.mode)
        MODE_EXT: {red_d, green_d, blue_d} = Pixel_i;
        MODE_BARS, MODE_CHECK: begin
          red_d   = {COLOR_BITS{pat_rgb[2]}};
          green_d = {COLOR_BITS{pat_rgb[1]}};
          blue_d  = {COLOR_BITS{pat_rgb[0]}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= MODE_EXT;
      for (int i = 0; i < LATENCY; i++) begin
        dly_q[i] <= CTL_BLANK;
      end
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= !H_POL;
      vsync_q <= !V_POL;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      for (int i = 0; i < LATENCY; i++) begin
        dly_q[i] <= dly_d[i];
      end
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
    end
  end

  vga_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (XW),
    .YW       (YW),
    .LATENCY  (LATENCY)
  ) u_pattern (
    .clk    (Clock),
    .rst    (Reset),
    .x_i    (h_q),
    .y_i    (v_q),
    .mode_i (mode_q),
    .rgb_o  (pat_rgb)
  );

  assign Request_o = cur_c.de;
  assign X_o       = h_q;
  assign Y_o       = v_q;
  assign Red_o     = red_q;
  assign Green_o   = green_q;
  assign Blue_o    = blue_q;
  assign HSync_o   = hsync_q;
  assign VSync_o   = vsync_q;
  assign DE_o      = de_q;
  assign Frame_o   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster with LATENCY=3, 4-bit colour and
// positive HSync; every cycle is compared against a position-based reference.
module tb_vga_timing_gen;

  localparam int HA  = 96;
  localparam int HF  = 4;
  localparam int HS  = 8;
  localparam int HB  = 4;
  localparam int VA  = 40;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FT  = HT * VT;
  localparam int LAT = 3;
  localparam int CB  = 4;
  localparam int PW  = 3 * CB;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b0;
  localparam int XW  = $clog2(HT);
  localparam int YW  = $clog2(VT);
  localparam int OW  = 1 + XW + YW + PW + 4;

  logic          Clock   = 1'b0;
  logic          Reset   = 1'b1;
  logic [1:0]    Mode_i  = 2'd0;
  logic [PW-1:0] Pixel_i = '0;
  logic          Request_o;
  logic [XW-1:0] X_o;
  logic [YW-1:0] Y_o;
  logic [CB-1:0] Red_o, Green_o, Blue_o;
  logic          HSync_o, VSync_o, DE_o, Frame_o;

  int errors  = 0;
  int checks  = 0;
  int k       = 0;
  int nframes = 0;
  int cur_mode;
  int mode_hist[$];
  logic [2:0] chk_tab [8];

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_POL(HP), .V_POL(VP), .COLOR_BITS(CB), .LATENCY(LAT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Mode_i(Mode_i), .Pixel_i(Pixel_i),
    .Request_o(Request_o), .X_o(X_o), .Y_o(Y_o),
    .Red_o(Red_o), .Green_o(Green_o), .Blue_o(Blue_o),
    .HSync_o(HSync_o), .VSync_o(VSync_o), .DE_o(DE_o), .Frame_o(Frame_o)
  );

  always #5 Clock = ~Clock;

  function automatic logic [PW-1:0] expand(input logic [2:0] c);
    return {{CB{c[2]}}, {CB{c[1]}}, {CB{c[0]}}};
  endfunction

  function automatic logic [OW-1:0] observed();
    return {Request_o, X_o, Y_o, Red_o, Green_o, Blue_o, HSync_o, VSync_o, DE_o, Frame_o};
  endfunction

  // Outputs at cycle k show raster position k-LAT-1; Pixel_i is the value held last cycle.
  function automatic logic [OW-1:0] expected();
    int pos, x, y, p, px, py;
    logic req, de, hs, vs, fr;
    logic [PW-1:0] rgb;
    pos = k % FT;
    x   = pos % HT;
    y   = pos / HT;
    req = (x < HA) && (y < VA);
    de = 1'b0; hs = 1'b0; vs = 1'b0; fr = 1'b0; rgb = '0;
    if (k >= LAT + 1) begin
      p  = k - LAT - 1;
      px = (p % FT) % HT;
      py = (p % FT) / HT;
      de = (px < HA) && (py < VA);
      hs = (px >= HA + HF) && (px < HA + HF + HS);
      vs = (py >= VA + VF) && (py < VA + VF + VS);
      fr = ((p % FT) == 0);
      if (de) begin
        case (mode_hist[p])
          0:       rgb = Pixel_i;
          1:       rgb = expand(3'(7 - (px * 8) / HA));
          2:       rgb = expand(chk_tab[3'(((px / 16) + (py / 16)) % 8)]);
          default: rgb = '0;
        endcase
      end
    end
    return {req, XW'(x), YW'(y), rgb, hs ? HP : !HP, vs ? VP : !VP, de, fr};
  endfunction

  task automatic check(input string tag);
    logic [OW-1:0] obs_v, exp_v;
    obs_v = observed();
    exp_v = expected();
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs_v, exp_v);
    end
  endtask

  task automatic check_frames(input string tag);
    int want;
    want = (k - LAT - 1) / FT + 1;
    checks++;
    assert (nframes === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, nframes, want);
    end
  endtask

  task automatic step(input int phase);
    int y;
    @(posedge Clock);
    #1;
    k++;
    if ((k % FT) == 0) cur_mode = int'(Mode_i);
    mode_hist.push_back(cur_mode);
    if (Frame_o) nframes++;
    check("cyc");
    y = (k % FT) / HT;
    Pixel_i = PW'($urandom);
    case (phase)
      0:       Mode_i = 2'd1;
      1:       Mode_i = (y < 20) ? 2'd1 : 2'd3;
      2:       Mode_i = 2'd2;
      default: Mode_i = 2'($urandom);
    endcase
  endtask

  task automatic run(input int n, input int phase);
    for (int i = 0; i < n && errors <= 20; i++) step(phase);
  endtask

  task automatic release_reset();
    Reset    = 1'b0;
    k        = 0;
    cur_mode = 0;
    nframes  = 0;
    mode_hist.delete();
    mode_hist.push_back(0);
    Pixel_i  = PW'($urandom);
    check("release");
  endtask

  initial begin
    chk_tab = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b000, 3'b111};
    Mode_i  = 2'd1;
    repeat (3) @(posedge Clock);
    #1;
    k = 0;
    check("reset");
    release_reset();
    run(FT, 0);        // external pixels, bars requested for next frame
    run(FT, 1);        // bars; request switches to black mid-frame
    run(FT, 2);        // black; checker requested
    run(3 * FT, 3);    // checker, then random mode requests
    check_frames("frame_count");
    run(20 * HT + 7, 3);
    #2 Reset = 1'b1;
    #1;
    k = 0;
    check("async_reset");
    Mode_i = 2'd2;
    repeat (2) @(posedge Clock);
    #1;
    check("held_reset");
    release_reset();
    run(FT + 2 * HT, 0);
    check_frames("frame_count_restart");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
